// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the arbitrated alu slice
package alu_pkg;
  localparam int DW = 4;
  localparam int STATS_W = 8;
  typedef logic [2:0] sel_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters, one consumer and the arbiter
interface alu_arbiter_if;
  import alu_pkg::*;
  logic [1:0] req_valid, req_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  sel_t req0_sel, req1_sel;
  logic rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [DW-1:0] rsp_y;
  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, busy
  );
  modport slave (
    input req_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 4-bit alu; carry is carry-out, borrow, or the shifted-out bit
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  sel_t          sel,
  output logic [DW-1:0] y,
  output logic          carry
);
  logic [DW:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign {carry, y} = sel == 3'd0 ? sum :
                      sel == 3'd1 ? dif :
                      sel == 3'd2 ? {1'b0, a & b} :
                      sel == 3'd3 ? {1'b0, a | b} :
                      sel == 3'd4 ? {1'b0, a ^ b} :
                      sel == 3'd5 ? {1'b0, ~a} :
                      sel == 3'd6 ? {a, 1'b0} :
                                    {a[0], 1'b0, a[DW-1:1]};
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one alu between two requesters (IDLE->EXEC->RESP)
// Optional per-requester grant counters when ALU_ARBITER_STATS_EN is defined.
module alu_arbiter #(
  parameter int DW = alu_pkg::DW
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ALU_ARBITER_STATS_EN
  alu_arbiter_if.slave bus,
  output logic [alu_pkg::STATS_W-1:0] grant_cnt0,
  output logic [alu_pkg::STATS_W-1:0] grant_cnt1
`else
  alu_arbiter_if.slave bus
`endif
);
  import alu_pkg::*;
  state_t state;
  logic last_grant, gnt_id, accept, alu_c;
  logic [DW-1:0] op_a, op_b, alu_y;
  sel_t op_sel;
  // reset gates acceptance so req_ready is low while rst_n is held
  assign accept = rst_n && state == IDLE && |bus.req_valid;
  assign gnt_id = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
  assign bus.req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy = state != IDLE;
  assign bus.rsp_valid = state == RESP;
  alu_arbiter_alu u_alu (
    .a(op_a),
    .b(op_b),
    .sel(op_sel),
    .y(alu_y),
    .carry(alu_c)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      op_a <= '0;
      op_b <= '0;
      op_sel <= '0;
      bus.rsp_id <= 1'b0;
      bus.rsp_y <= '0;
      bus.rsp_carry <= 1'b0;
    end else if (accept) begin
      state <= EXEC;
      last_grant <= gnt_id;
      op_a <= gnt_id ? bus.req1_a : bus.req0_a;
      op_b <= gnt_id ? bus.req1_b : bus.req0_b;
      op_sel <= gnt_id ? bus.req1_sel : bus.req0_sel;
      bus.rsp_id <= gnt_id;
    end else if (state == EXEC) begin
      state <= RESP;
      bus.rsp_y <= alu_y;
      bus.rsp_carry <= alu_c;
    end else if (state == RESP && bus.rsp_ready) begin
      state <= IDLE;
    end
  end
`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt_id && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt_id && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif
endmodule
